dma_chan_sched: RTL and testbench

- Round-robin scheduler that shares one single-channel DMA engine among NUM_CH requesting channels.
- Arbitrates requests, latches the winner's direction and length, then drives the engine start pulse, the read/write enable window and the transfer length.
- Waits for the engine completion interrupt, or a timeout, and returns a per-channel done or error pulse.
- Sits between the channel request logic and the DMA engine FSM.

---
 rtl/dma_pkg.sv | 23 ++
 rtl/dma_rr_arb.sv | 40 ++++
 rtl/dma_chan_sched.sv | 165 ++++++++++++++++
 tb/tb_dma_chan_sched.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_pkg.sv
// Shared types and helpers for the DMA channel scheduler.
package dma_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ARB,
      START,
      EN,
      WAIT,
      DONE
   } state_e;

   localparam logic DIR_RD = 1'b0;
   localparam logic DIR_WR = 1'b1;

   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      while ((64'(1) << r) < 64'(v)) r++;
      return r;
   endfunction

endpackage

// File: rtl/dma_rr_arb.sv
// Rotating-priority arbiter: first request strictly above last, wrapping.
module dma_rr_arb
#(
   parameter int unsigned NUM_CH = 4,
   parameter int unsigned IW     = 2
)
(
   input  logic [NUM_CH-1:0] req,
   input  logic [IW-1:0]     last,
   output logic [NUM_CH-1:0] gnt_c,
   output logic [IW-1:0]     idx_c,
   output logic              any_c
);

   logic [2*NUM_CH-1:0] dbl;
   logic [2*NUM_CH-1:0] masked;

   // Doubled request vector with everything at or below last masked off.
   always_comb begin
      dbl    = {req, req};
      masked = '0;
      for (int unsigned j = 0; j < 2*NUM_CH; j++) begin
         if (j > 32'(last)) masked[j] = dbl[j];
      end
   end

   always_comb begin
      gnt_c = '0;
      idx_c = '0;
      any_c = 1'b0;
      for (int unsigned j = 0; j < 2*NUM_CH; j++) begin
         if (!any_c && masked[j]) begin
            any_c = 1'b1;
            idx_c = (j >= NUM_CH) ? IW'(j - NUM_CH) : IW'(j);
         end
      end
      if (any_c) gnt_c = NUM_CH'(1) << idx_c;
   end

endmodule

// File: rtl/dma_chan_sched.sv
// Round-robin scheduler sharing one DMA engine among NUM_CH channels.
module dma_chan_sched
   import dma_pkg::*;
#(
   parameter int unsigned NUM_CH  = 4,
   parameter int unsigned WIDTH   = 8,
   parameter int unsigned TIMEOUT = 64
)
(
   input  logic                     clk,
   input  logic                     arst_n,
   input  logic [NUM_CH-1:0]        req,
   input  logic [NUM_CH-1:0]        req_dir,
   input  logic [NUM_CH*WIDTH-1:0]  req_len,
   output logic [NUM_CH-1:0]        grant,
   output logic [NUM_CH-1:0]        done,
   output logic                     err,
   output logic                     eng_start,
   output logic                     eng_rd_en,
   output logic                     eng_wr_en,
   output logic [WIDTH-1:0]         eng_len,
   input  logic                     eng_irq
);

   localparam int unsigned IW = clog2(NUM_CH);
   localparam int unsigned TW = clog2(TIMEOUT);

   state_e              state_q, state_d;
   logic [IW-1:0]       last_q, last_d;
   logic [IW-1:0]       ch_q, ch_d;
   logic                dir_q, dir_d;
   logic [WIDTH-1:0]    len_q, len_d;
   logic [WIDTH-1:0]    beat_q, beat_d;
   logic [TW-1:0]       timer_q, timer_d;
   logic [NUM_CH-1:0]   grant_q, grant_d;
   logic [NUM_CH-1:0]   done_q, done_d;
   logic                err_q, err_d;
   logic                start_q, start_d;
   logic                rd_q, rd_d;
   logic                wr_q, wr_d;

   logic [NUM_CH-1:0]   arb_gnt_c;
   logic [IW-1:0]       arb_idx_c;
   logic                arb_any_c;

   dma_rr_arb #(.NUM_CH(NUM_CH), .IW(IW)) u_arb (
      .req   (req),
      .last  (last_q),
      .gnt_c (arb_gnt_c),
      .idx_c (arb_idx_c),
      .any_c (arb_any_c)
   );

   // Next state; every output is computed here and registered below.
   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      ch_d    = ch_q;
      dir_d   = dir_q;
      len_d   = len_q;
      beat_d  = beat_q;
      timer_d = timer_q;
      grant_d = grant_q;
      done_d  = '0;
      err_d   = 1'b0;
      start_d = 1'b0;
      rd_d    = 1'b0;
      wr_d    = 1'b0;
      unique case (state_q)
         IDLE: if (|req) state_d = ARB;
         ARB: begin
            if (arb_any_c) begin
               state_d = START;
               grant_d = arb_gnt_c;
               ch_d    = arb_idx_c;
               start_d = 1'b1;
               for (int unsigned i = 0; i < NUM_CH; i++) begin
                  if (arb_gnt_c[i]) begin
                     dir_d = req_dir[i];
                     len_d = req_len[i*WIDTH +: WIDTH];
                  end
               end
            end else begin
               state_d = IDLE;
            end
         end
         START: begin
            state_d = EN;
            beat_d  = '0;
            rd_d    = (dir_q == DIR_RD);
            wr_d    = (dir_q == DIR_WR);
         end
         EN: begin
            if (beat_q == len_q) begin
               state_d = WAIT;
               timer_d = '0;
            end else begin
               beat_d = beat_q + WIDTH'(1);
               rd_d   = (dir_q == DIR_RD);
               wr_d   = (dir_q == DIR_WR);
            end
         end
         WAIT: begin
            if (eng_irq) begin
               state_d = DONE;
               done_d  = grant_q;
            end else if (timer_q == TW'(TIMEOUT-1)) begin
               state_d = DONE;
               done_d  = grant_q;
               err_d   = 1'b1;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         DONE: begin
            state_d = IDLE;
            grant_d = '0;
            len_d   = '0;
            last_d  = ch_q;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state_q <= IDLE;
         last_q  <= IW'(NUM_CH-1);
         ch_q    <= '0;
         dir_q   <= 1'b0;
         len_q   <= '0;
         beat_q  <= '0;
         timer_q <= '0;
         grant_q <= '0;
         done_q  <= '0;
         err_q   <= 1'b0;
         start_q <= 1'b0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         ch_q    <= ch_d;
         dir_q   <= dir_d;
         len_q   <= len_d;
         beat_q  <= beat_d;
         timer_q <= timer_d;
         grant_q <= grant_d;
         done_q  <= done_d;
         err_q   <= err_d;
         start_q <= start_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
      end
   end

   assign grant     = grant_q;
   assign done      = done_q;
   assign err       = err_q;
   assign eng_start = start_q;
   assign eng_rd_en = rd_q;
   assign eng_wr_en = wr_q;
   assign eng_len   = len_q;

endmodule

// File: tb/tb_dma_chan_sched.sv
// Directed bench for dma_chan_sched: one task per scenario, inline checks.
module tb_dma_chan_sched;

   localparam int unsigned NUM_CH  = 4;
   localparam int unsigned WIDTH   = 8;
   localparam int unsigned TIMEOUT = 64;

   logic                    clk = 1'b0;
   logic                    arst_n;
   logic [NUM_CH-1:0]       req;
   logic [NUM_CH-1:0]       req_dir;
   logic [NUM_CH*WIDTH-1:0] req_len;
   logic [NUM_CH-1:0]       grant;
   logic [NUM_CH-1:0]       done;
   logic                    err;
   logic                    eng_start;
   logic                    eng_rd_en;
   logic                    eng_wr_en;
   logic [WIDTH-1:0]        eng_len;
   logic                    eng_irq;

   int n_checks = 0;
   int n_fail   = 0;

   dma_chan_sched #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
      .clk       (clk),
      .arst_n    (arst_n),
      .req       (req),
      .req_dir   (req_dir),
      .req_len   (req_len),
      .grant     (grant),
      .done      (done),
      .err       (err),
      .eng_start (eng_start),
      .eng_rd_en (eng_rd_en),
      .eng_wr_en (eng_wr_en),
      .eng_len   (eng_len),
      .eng_irq   (eng_irq)
   );

   always #5 clk = ~clk;

   // {grant, done, err, start, rd, wr, len}
   function automatic logic [19:0] pk(input logic [3:0] g, input logic [3:0] d, input logic e,
                                      input logic s, input logic r, input logic w,
                                      input logic [7:0] l);
      return {g, d, e, s, r, w, l};
   endfunction

   function automatic logic [19:0] obs();
      return {grant, done, err, eng_start, eng_rd_en, eng_wr_en, eng_len};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_len(input int ch, input logic [7:0] l);
      req_len[ch*WIDTH +: WIDTH] = l;
   endtask

   task automatic wait_start();
      for (int c = 0; c < 64 && eng_start !== 1'b1; c++) step();
   endtask

   task automatic wait_done();
      for (int c = 0; c < 200 && done === 4'b0000; c++) begin
         step();
         if (eng_start === 1'b1) req = '0;
      end
   endtask

   task automatic apply_reset();
      arst_n  = 1'b0;
      req     = '0;
      eng_irq = 1'b0;
      step();
      step();
      arst_n = 1'b1;
      step();
   endtask

   task automatic test_reset();
      arst_n  = 1'b0;
      req     = '0;
      req_dir = '0;
      req_len = '0;
      eng_irq = 1'b0;
      #1;
      n_checks++;
      if (obs() !== 20'h0) begin
         n_fail++;
         $display("FAIL reset_during: got %h expected %h", obs(), 20'h0);
      end
      step();
      step();
      arst_n = 1'b1;
      step();
      step();
      n_checks++;
      if (obs() !== 20'h0) begin
         n_fail++;
         $display("FAIL reset_idle: got %h expected %h", obs(), 20'h0);
      end
   endtask

   task automatic test_single_read();
      logic [19:0] exp;
      req_dir = '0;
      set_len(0, 8'd3);
      req     = 4'b0001;
      eng_irq = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         step();
         if (k == 2) req = '0;
         case (k)
            1:          exp = pk(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
            2:          exp = pk(4'b0001, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 8'd3);
            3, 4, 5, 6: exp = pk(4'b0001, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 8'd3);
            7, 8:       exp = pk(4'b0001, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 8'd3);
            9:          exp = pk(4'b0001, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0, 8'd3);
            default:    exp = pk(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
         endcase
         n_checks++;
         if (obs() !== exp) begin
            n_fail++;
            $display("FAIL single_read cycle %0d: got %h expected %h", k, obs(), exp);
         end
         eng_irq = (k == 8);
      end
   endtask

   task automatic test_fairness();
      logic [3:0] order [7];
      order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b1000, 4'b0001};
      apply_reset();
      for (int i = 0; i < NUM_CH; i++) set_len(i, 8'd1);
      req_dir = '0;
      eng_irq = 1'b1;
      req     = 4'b1111;
      for (int i = 0; i < 7; i++) begin
         wait_start();
         n_checks++;
         if (eng_start !== 1'b1 || grant !== order[i]) begin
            n_fail++;
            $display("FAIL fair_grant %0d: got start=%b grant=%b expected grant %b",
                     i, eng_start, grant, order[i]);
         end
         for (int c = 0; c < 50 && done === 4'b0000; c++) step();
         n_checks++;
         if (done !== order[i] || err !== 1'b0) begin
            n_fail++;
            $display("FAIL fair_done %0d: got done=%b err=%b expected %b err 0",
                     i, done, err, order[i]);
         end
         if (i == 4) req = 4'b1001;
         if (i == 6) req = '0;
      end
      eng_irq = 1'b0;
      step();
   endtask

   task automatic test_write_len0();
      int wr_n = 0;
      int rd_n = 0;
      req_dir = 4'b0100;
      set_len(2, 8'd0);
      eng_irq = 1'b1;
      req     = 4'b0100;
      wait_start();
      req = '0;
      n_checks++;
      if ({eng_start, grant, eng_len} !== {1'b1, 4'b0100, 8'd0}) begin
         n_fail++;
         $display("FAIL wr0_start: got start=%b grant=%b len=%0d expected 1 0100 0",
                  eng_start, grant, eng_len);
      end
      for (int c = 0; c < 20 && done === 4'b0000; c++) begin
         step();
         if (eng_wr_en === 1'b1) wr_n++;
         if (eng_rd_en === 1'b1) rd_n++;
      end
      n_checks++;
      if (wr_n != 1 || rd_n != 0) begin
         n_fail++;
         $display("FAIL wr0_enables: got wr=%0d rd=%0d cycles expected 1 and 0", wr_n, rd_n);
      end
      n_checks++;
      if (done !== 4'b0100 || err !== 1'b0) begin
         n_fail++;
         $display("FAIL wr0_done: got done=%b err=%b expected 0100 0", done, err);
      end
      eng_irq = 1'b0;
      req_dir = '0;
      step();
   endtask

   task automatic test_timeout();
      int n = 0;
      eng_irq = 1'b0;
      req_dir = '0;
      set_len(0, 8'd0);
      req = 4'b0001;
      wait_start();
      req = '0;
      step();
      step();
      n_checks++;
      if ({grant, eng_rd_en, done} !== {4'b0001, 1'b0, 4'b0000}) begin
         n_fail++;
         $display("FAIL to_wait_entry: got grant=%b rd=%b done=%b expected 0001 0 0000",
                  grant, eng_rd_en, done);
      end
      while (done === 4'b0000 && n < 100) begin
         step();
         n++;
      end
      n_checks++;
      if (n != 64 || done !== 4'b0001 || err !== 1'b1) begin
         n_fail++;
         $display("FAIL timeout: got %0d cycles done=%b err=%b expected 64 0001 1", n, done, err);
      end
      step();
      n_checks++;
      if (err !== 1'b0 || done !== 4'b0000) begin
         n_fail++;
         $display("FAIL timeout_pulse: got done=%b err=%b expected 0000 0", done, err);
      end
      req     = 4'b0010;
      eng_irq = 1'b1;
      wait_done();
      n_checks++;
      if (done !== 4'b0010 || err !== 1'b0) begin
         n_fail++;
         $display("FAIL after_timeout: got done=%b err=%b expected 0010 0", done, err);
      end
      eng_irq = 1'b0;
      step();
   endtask

   task automatic test_reset_mid();
      logic seen_done = 1'b0;
      eng_irq = 1'b0;
      req_dir = '0;
      set_len(0, 8'd10);
      req = 4'b0001;
      wait_start();
      req = '0;
      step();
      step();
      step();
      n_checks++;
      if (eng_rd_en !== 1'b1 || grant !== 4'b0001) begin
         n_fail++;
         $display("FAIL mid_en: got rd=%b grant=%b expected 1 0001", eng_rd_en, grant);
      end
      arst_n = 1'b0;
      #1;
      n_checks++;
      if (obs() !== 20'h0) begin
         n_fail++;
         $display("FAIL mid_reset_async: got %h expected %h", obs(), 20'h0);
      end
      step();
      arst_n = 1'b1;
      for (int c = 0; c < 5; c++) begin
         step();
         if (done !== 4'b0000 || err !== 1'b0) seen_done = 1'b1;
      end
      n_checks++;
      if (seen_done !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_reset_no_done: got done seen=%b expected 0", seen_done);
      end
      req = 4'b0110;
      wait_start();
      n_checks++;
      if (eng_start !== 1'b1 || grant !== 4'b0010) begin
         n_fail++;
         $display("FAIL ptr_reset_grant: got start=%b grant=%b expected 1 0010", eng_start, grant);
      end
      req     = '0;
      eng_irq = 1'b1;
      wait_done();
      eng_irq = 1'b0;
      step();
   endtask

   task automatic test_latching();
      int en_n = 0;
      logic early_done = 1'b0;
      eng_irq = 1'b0;
      req_dir = '0;
      set_len(2, 8'd5);
      req = 4'b0100;
      wait_start();
      req = '0;
      n_checks++;
      if (eng_start !== 1'b1 || eng_len !== 8'd5) begin
         n_fail++;
         $display("FAIL latch_start: got start=%b len=%0d expected 1 5", eng_start, eng_len);
      end
      step();
      set_len(2, 8'd200);
      req_dir = 4'b0100;
      eng_irq = 1'b1;
      for (int c = 0; c < 20 && (eng_rd_en === 1'b1 || eng_wr_en === 1'b1); c++) begin
         n_checks++;
         if ({eng_rd_en, eng_wr_en, eng_len} !== {1'b1, 1'b0, 8'd5}) begin
            n_fail++;
            $display("FAIL latch_en cycle %0d: got rd=%b wr=%b len=%0d expected 1 0 5",
                     c, eng_rd_en, eng_wr_en, eng_len);
         end
         en_n++;
         step();
         eng_irq = 1'b0;
      end
      n_checks++;
      if (en_n != 6) begin
         n_fail++;
         $display("FAIL latch_en_len: got %0d cycles expected 6", en_n);
      end
      for (int c = 0; c < 3; c++) begin
         if (done !== 4'b0000) early_done = 1'b1;
         step();
      end
      n_checks++;
      if (early_done !== 1'b0 || done !== 4'b0000) begin
         n_fail++;
         $display("FAIL latch_early_irq: got early done=%b expected 0", early_done);
      end
      eng_irq = 1'b1;
      step();
      eng_irq = 1'b0;
      n_checks++;
      if (done !== 4'b0100 || err !== 1'b0) begin
         n_fail++;
         $display("FAIL latch_done: got done=%b err=%b expected 0100 0", done, err);
      end
      req_dir = '0;
      step();
   endtask

   initial begin
      test_reset();
      test_single_read();
      test_fairness();
      test_write_len0();
      test_timeout();
      test_reset_mid();
      test_latching();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
